// File: rtl/jtkicker_pkg.sv
// Shared definitions for the Kicker SN76489 write-side bus responder.
// Holds the register address map and the handshake state encoding.
// Imported by the bus top and the register-file sub-module.
package jtkicker_pkg;

    // SN76489 register addresses as carried in a latch byte, bits [6:4]
    localparam logic [2:0] TONE0 = 3'd0;
    localparam logic [2:0] VOL0  = 3'd1;
    localparam logic [2:0] TONE1 = 3'd2;
    localparam logic [2:0] VOL1  = 3'd3;
    localparam logic [2:0] TONE2 = 3'd4;
    localparam logic [2:0] VOL2  = 3'd5;
    localparam logic [2:0] NOISE = 3'd6;
    localparam logic [2:0] VOL3  = 3'd7;

    // Write handshake states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ti_state_t;

    // Every odd address is an attenuation register
    function automatic logic is_vol(input logic [2:0] addr);
        return addr[0];
    endfunction

endpackage

// File: rtl/jtkicker_ti_bus_if.sv
// CPU-to-PSG write bus plus the decoded register outputs.
// master: CPU side (drives clk_en, strobes, data; observes ready and registers).
// slave : PSG responder (drives ready and the register file outputs).
interface jtkicker_ti_bus_if;
    logic       clk_en;     // PSG clock enable, paces the write stall
    logic       ce_n;       // chip enable, active low
    logic       wr_n;       // write enable, active low
    logic [7:0] din;        // data byte from the CPU latch
    logic       ready;      // high = able to accept a write
    logic [9:0] tone0;
    logic [9:0] tone1;
    logic [9:0] tone2;
    logic [2:0] noise_ctl;  // {FB, NF1, NF0}
    logic [3:0] vol0;
    logic [3:0] vol1;
    logic [3:0] vol2;
    logic [3:0] vol3;       // noise channel attenuation
    logic       noise_rst;  // one-clk LFSR reload pulse

    modport master (
        output clk_en, ce_n, wr_n, din,
        input  ready, tone0, tone1, tone2, noise_ctl,
        input  vol0, vol1, vol2, vol3, noise_rst
    );

    modport slave (
        input  clk_en, ce_n, wr_n, din,
        output ready, tone0, tone1, tone2, noise_ctl,
        output vol0, vol1, vol2, vol3, noise_rst
    );
endinterface

// File: rtl/jtkicker_ti_regs.sv
// SN76489 latch/data byte decoder and register file.
// Ports: clk, rst, i_apply (one-clk write strobe), i_byte (byte to decode);
//        o_tone0..2, o_noise_ctl, o_vol0..3, o_noise_rst (registered outputs).
module jtkicker_ti_regs
    import jtkicker_pkg::*;
#(
    parameter logic [3:0] VOL_RST = 4'hF
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_apply,
    input  logic [7:0] i_byte,
    output logic [9:0] o_tone0,
    output logic [9:0] o_tone1,
    output logic [9:0] o_tone2,
    output logic [2:0] o_noise_ctl,
    output logic [3:0] o_vol0,
    output logic [3:0] o_vol1,
    output logic [3:0] o_vol2,
    output logic [3:0] o_vol3,
    output logic       o_noise_rst
);

    logic [2:0] r_addr;
    logic [9:0] r_tone0, r_tone1, r_tone2;
    logic [2:0] r_noise_ctl;
    logic [3:0] r_vol [0:3];
    logic       r_noise_rst;

    logic       w_latch;
    logic [2:0] w_addr;

    // A latch byte targets its own address immediately; a data byte reuses
    // whatever address the last latch byte left behind.
    assign w_latch = i_byte[7];
    assign w_addr  = w_latch ? i_byte[6:4] : r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= TONE0;
            r_tone0     <= '0;
            r_tone1     <= '0;
            r_tone2     <= '0;
            r_noise_ctl <= '0;
            r_noise_rst <= 1'b0;
            for (int i = 0; i < 4; i++) r_vol[i] <= VOL_RST;
        end else begin
            r_noise_rst <= 1'b0;
            if (i_apply) begin
                if (w_latch) r_addr <= i_byte[6:4];
                if (w_addr == NOISE) begin
                    r_noise_ctl <= i_byte[2:0];
                    r_noise_rst <= 1'b1;
                end else if (is_vol(w_addr)) begin
                    // addresses 1/3/5/7 map onto channels 0..3
                    r_vol[w_addr[2:1]] <= i_byte[3:0];
                end else if (w_latch) begin
                    case (w_addr)
                        TONE0:   r_tone0[3:0] <= i_byte[3:0];
                        TONE1:   r_tone1[3:0] <= i_byte[3:0];
                        default: r_tone2[3:0] <= i_byte[3:0];
                    endcase
                end else begin
                    case (w_addr)
                        TONE0:   r_tone0[9:4] <= i_byte[5:0];
                        TONE1:   r_tone1[9:4] <= i_byte[5:0];
                        default: r_tone2[9:4] <= i_byte[5:0];
                    endcase
                end
            end
        end
    end

    assign o_tone0     = r_tone0;
    assign o_tone1     = r_tone1;
    assign o_tone2     = r_tone2;
    assign o_noise_ctl = r_noise_ctl;
    assign o_vol0      = r_vol[0];
    assign o_vol1      = r_vol[1];
    assign o_vol2      = r_vol[2];
    assign o_vol3      = r_vol[3];
    assign o_noise_rst = r_noise_rst;

endmodule

// File: rtl/jtkicker_ti_bus.sv
// Write-side bus responder for an SN76489-compatible PSG.
// Ports: clk, rst (sync, active high); bus (slave modport): strobes, din,
//        clk_en in; ready and the decoded register file out.
module jtkicker_ti_bus
    import jtkicker_pkg::*;
#(
    parameter int         WAIT_CYC = 32,
    parameter logic [3:0] VOL_RST  = 4'hF
)(
    input  logic             clk,
    input  logic             rst,
    jtkicker_ti_bus_if.slave bus
);

    localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYC - 1);

    ti_state_t   r_state;
    logic [CW-1:0] r_count;
    logic [7:0]  r_byte;
    logic        r_ready;

    logic        w_strobe;
    logic        w_apply;

    assign w_strobe = ~bus.ce_n & ~bus.wr_n;
    // The register file updates on the same edge that ready rises.
    assign w_apply  = (r_state == ST_WAIT) && bus.clk_en && (r_count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_byte  <= '0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A clk_en coinciding with the strobe is not counted.
                    if (w_strobe) begin
                        r_byte  <= bus.din;
                        r_ready <= 1'b0;
                        r_count <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_apply) begin
                        r_ready <= 1'b1;
                        r_state <= ST_HOLD;
                    end else if (bus.clk_en) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_HOLD: begin
                    // A strobe still held from the finished write must not re-trigger.
                    if (!w_strobe) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready = r_ready;

    jtkicker_ti_regs #(.VOL_RST(VOL_RST)) u_regs (
        .clk         (clk),
        .rst         (rst),
        .i_apply     (w_apply),
        .i_byte      (r_byte),
        .o_tone0     (bus.tone0),
        .o_tone1     (bus.tone1),
        .o_tone2     (bus.tone2),
        .o_noise_ctl (bus.noise_ctl),
        .o_vol0      (bus.vol0),
        .o_vol1      (bus.vol1),
        .o_vol2      (bus.vol2),
        .o_vol3      (bus.vol3),
        .o_noise_rst (bus.noise_rst)
    );

endmodule

// File: tb/tb_jtkicker_ti_bus.sv
// Directed bench for jtkicker_ti_bus: table of writes with expected register
// state, plus hand sequences for held strobe, stalled clk_en and mid-write reset.
module tb_jtkicker_ti_bus;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   en_on = 1'b1;
    int   ecnt = 0;

    jtkicker_ti_bus_if bus();

    jtkicker_ti_bus #(.WAIT_CYC(32), .VOL_RST(4'hF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // clk_en every 4th clock, changed on the falling edge
    always @(negedge clk) begin
        ecnt = ecnt + 1;
        bus.clk_en = en_on && (ecnt % 4 == 0);
    end

    // Edge monitor: noise_rst high cycles / rises, ready-low clk_en ticks, ready falls
    int hi_cnt = 0, rise_cnt = 0, tick_cnt = 0, fall_cnt = 0;
    logic prev_nr = 1'b0, prev_rdy = 1'b1;
    always @(posedge clk) begin
        if (bus.noise_rst === 1'b1) hi_cnt = hi_cnt + 1;
        if (bus.noise_rst === 1'b1 && prev_nr !== 1'b1) rise_cnt = rise_cnt + 1;
        prev_nr = bus.noise_rst;
        if (bus.ready === 1'b0 && bus.clk_en === 1'b1) tick_cnt = tick_cnt + 1;
        if (prev_rdy === 1'b1 && bus.ready === 1'b0) fall_cnt = fall_cnt + 1;
        prev_rdy = bus.ready;
    end

    int n_chk = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        hi_cnt = 0; rise_cnt = 0; tick_cnt = 0; fall_cnt = 0;
    endtask

    // Assert the strobe with din; optionally in a clock where clk_en is high
    task automatic start_write(input logic [7:0] d, input bit align);
        @(negedge clk); #1;
        if (align) begin
            for (int k = 0; k < 8 && !bus.clk_en; k++) begin
                @(negedge clk); #1;
            end
        end
        clear_mon();
        bus.din = d; bus.ce_n = 1'b0; bus.wr_n = 1'b0;
    endtask

    task automatic release_strobe();
        bus.ce_n = 1'b1; bus.wr_n = 1'b1; bus.din = 8'h5A;
    endtask

    task automatic wait_ready(input string nm);
        for (int k = 0; k < 3000 && bus.ready !== 1'b1; k++) @(negedge clk);
        if (bus.ready !== 1'b1) chk({nm, " ready timeout"}, bus.ready, 1);
    endtask

    typedef struct {
        logic [7:0] din;
        bit         align;
        logic [9:0] t0, t1, t2;
        logic [2:0] nz;
        logic [3:0] v0, v1, v2, v3;
        int         pulses;
    } vec_t;

    vec_t vt [9];

    initial begin
        vt[0] = '{8'h8E, 1, 10'h00E, 10'h000, 10'h000, 3'b000, 4'hF, 4'hF, 4'hF, 4'hF, 0};
        vt[1] = '{8'h0F, 0, 10'h0FE, 10'h000, 10'h000, 3'b000, 4'hF, 4'hF, 4'hF, 4'hF, 0};
        vt[2] = '{8'h95, 1, 10'h0FE, 10'h000, 10'h000, 3'b000, 4'h5, 4'hF, 4'hF, 4'hF, 0};
        vt[3] = '{8'hE5, 0, 10'h0FE, 10'h000, 10'h000, 3'b101, 4'h5, 4'hF, 4'hF, 4'hF, 1};
        vt[4] = '{8'h03, 1, 10'h0FE, 10'h000, 10'h000, 3'b011, 4'h5, 4'hF, 4'hF, 4'hF, 1};
        vt[5] = '{8'hA7, 0, 10'h0FE, 10'h007, 10'h000, 3'b011, 4'h5, 4'hF, 4'hF, 4'hF, 0};
        vt[6] = '{8'h3F, 1, 10'h0FE, 10'h3F7, 10'h000, 3'b011, 4'h5, 4'hF, 4'hF, 4'hF, 0};
        vt[7] = '{8'hFA, 0, 10'h0FE, 10'h3F7, 10'h000, 3'b011, 4'h5, 4'hF, 4'hF, 4'hA, 0};
        vt[8] = '{8'h02, 1, 10'h0FE, 10'h3F7, 10'h000, 3'b011, 4'h5, 4'hF, 4'hF, 4'h2, 0};

        bus.ce_n = 1'b1; bus.wr_n = 1'b1; bus.din = 8'h00;

        // Reset state
        repeat (4) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        chk("rst ready", bus.ready, 1);
        chk("rst tone0", bus.tone0, 0);
        chk("rst tone1", bus.tone1, 0);
        chk("rst tone2", bus.tone2, 0);
        chk("rst noise", bus.noise_ctl, 0);
        chk("rst vols", {bus.vol0, bus.vol1, bus.vol2, bus.vol3}, 16'hFFFF);
        chk("rst nrst", hi_cnt, 0);

        // Table-driven writes
        for (int i = 0; i < 9; i++) begin
            start_write(vt[i].din, vt[i].align);
            @(negedge clk);
            chk($sformatf("v%0d ready low", i), bus.ready, 0);
            release_strobe();
            wait_ready($sformatf("v%0d", i));
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d tone0", i), bus.tone0, vt[i].t0);
            chk($sformatf("v%0d tone1", i), bus.tone1, vt[i].t1);
            chk($sformatf("v%0d tone2", i), bus.tone2, vt[i].t2);
            chk($sformatf("v%0d noise", i), bus.noise_ctl, vt[i].nz);
            chk($sformatf("v%0d vols", i), {bus.vol0, bus.vol1, bus.vol2, bus.vol3},
                {vt[i].v0, vt[i].v1, vt[i].v2, vt[i].v3});
            chk($sformatf("v%0d nrst rises", i), rise_cnt, vt[i].pulses);
            chk($sformatf("v%0d nrst width", i), hi_cnt, vt[i].pulses);
            chk($sformatf("v%0d ticks", i), tick_cnt, 32);
            chk($sformatf("v%0d falls", i), fall_cnt, 1);
        end

        // Stalled clk_en keeps the write pending indefinitely
        start_write(8'hB0, 0);
        @(negedge clk);
        release_strobe();
        repeat (20) @(negedge clk);
        en_on = 1'b0;
        repeat (300) @(negedge clk);
        chk("stall ready", bus.ready, 0);
        chk("stall vol1", bus.vol1, 4'hF);
        en_on = 1'b1;
        wait_ready("stall");
        repeat (2) @(negedge clk);
        chk("stall vol1 after", bus.vol1, 4'h0);
        chk("stall ticks", tick_cnt, 32);

        // Strobe held for 200 clk: one update only
        start_write(8'hC3, 0);
        repeat (200) @(negedge clk);
        chk("hold ready", bus.ready, 1);
        chk("hold tone2", bus.tone2, 10'h003);
        chk("hold falls", fall_cnt, 1);
        chk("hold ticks", tick_cnt, 32);
        release_strobe();
        repeat (10) @(negedge clk);
        chk("hold release ready", bus.ready, 1);
        chk("hold release falls", fall_cnt, 1);

        // Data byte reuses the latched tone2 address
        start_write(8'h15, 1);
        @(negedge clk);
        release_strobe();
        wait_ready("persist");
        repeat (2) @(negedge clk);
        chk("persist tone2", bus.tone2, 10'h153);
        chk("persist tone0", bus.tone0, 10'h0FE);

        // Reset at tick 10 of a vol1 write aborts it
        start_write(8'hBF, 0);
        @(negedge clk);
        release_strobe();
        for (int k = 0; k < 500 && tick_cnt < 10; k++) @(negedge clk);
        chk("abort reached tick10", tick_cnt, 10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort ready", bus.ready, 1);
        chk("abort vol1", bus.vol1, 4'hF);
        chk("abort tone0", bus.tone0, 0);
        chk("abort vol0", bus.vol0, 4'hF);
        repeat (200) @(negedge clk);
        chk("abort late ready", bus.ready, 1);
        chk("abort late vol1", bus.vol1, 4'hF);
        chk("abort late nrst", hi_cnt, 0);
        chk("abort falls", fall_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
